// File: rtl/vctrl_mode_loader.sv
// vctrl_mode_loader
//   Programs a preset video timing mode into the video-control register file
//   through the file's single address/data write port, which it shares with
//   the host. The host always wins the port; the loader simply stalls.
//   Sequence: blank (0x0c, video off) -> timing bytes 0x00-0x0b -> enable
//   (0x0c, video on), so video is never enabled on half-written timing.
//   Build macro VCTRL_LOADER_VERIFY_EN adds a readback pass over 0x00-0x0c
//   that latches o_verify_fail on any mismatch; without it the flag is 0.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_host_addr/_data         host register address / write data
//   i_host_select/_wr_req     host access this cycle / host write strobe
//   o_host_data               host readback, straight from i_data_rd
//   i_mode, i_out_sel         preset index / {vga, hdmi} enables, taken with i_start
//   i_start                   one-cycle load request
//   o_busy, o_done, o_err     load running / completion pulse / bad-mode pulse
//   o_verify_fail             latched readback mismatch
//   o_addr, o_data_wr         register-file address / write data
//   o_select, o_wr_req        register-file select / write strobe
//   i_data_rd                 register-file combinational readback
//
// state  | meaning
// IDLE   | waiting for i_start
// BLANK  | write 0x0c with video off
// LOAD   | write timing bytes 0x00-0x0b
// ENABLE | write 0x0c with video and outputs on
// VERIFY | read back 0x00-0x0c and compare (verify build only)
// FINISH | one-cycle done pulse, back to IDLE
module vctrl_mode_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic              i_host_select,
  input  logic              i_host_wr_req,
  output logic [DATA_W-1:0] o_host_data,
  input  logic [2:0]        i_mode,
  input  logic [1:0]        i_out_sel,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_verify_fail,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data_wr,
  output logic              o_select,
  output logic              o_wr_req,
  input  logic [DATA_W-1:0] i_data_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_BLANK, S_LOAD, S_ENABLE, S_VERIFY, S_FINISH
  } state_t;

  localparam logic [3:0] LAST_TIMING = 4'd11;
  localparam logic [3:0] CTRL_IDX    = 4'd12;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] out_sel_q, out_sel_d;
  logic [3:0] idx_q, idx_d;
  logic       err_q, err_d;
`ifdef VCTRL_LOADER_VERIFY_EN
  logic       vfail_q, vfail_d;
`endif

  logic [11:0] h_act, h_ss, h_se, h_bl, v_act, v_ss, v_se, v_bl;
  logic        hpol, vpol;
  logic [7:0]  ctrl_off, ctrl_on, exp_byte;
  logic        ld_sel, ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic        grant;

  function automatic logic [7:0] pack_byte(input logic [2:0] sel,
                                           input logic [11:0] act, ss, se, bl);
    logic [7:0] b;
    case (sel)
      3'd0:    b = act[7:0];
      3'd1:    b = {ss[3:0], act[11:8]};
      3'd2:    b = ss[11:4];
      3'd3:    b = se[7:0];
      3'd4:    b = {bl[3:0], se[11:8]};
      default: b = bl[11:4];
    endcase
    return b;
  endfunction

  always_comb begin
    case (mode_q)
      2'd1: begin
        h_act = 12'd800;  h_ss = 12'd840;  h_se = 12'd968;  h_bl = 12'd1056;
        v_act = 12'd600;  v_ss = 12'd601;  v_se = 12'd605;  v_bl = 12'd628;
        hpol = 1'b1; vpol = 1'b1;
      end
      2'd2: begin
        h_act = 12'd1280; h_ss = 12'd1390; h_se = 12'd1430; h_bl = 12'd1650;
        v_act = 12'd720;  v_ss = 12'd725;  v_se = 12'd730;  v_bl = 12'd750;
        hpol = 1'b1; vpol = 1'b1;
      end
      2'd3: begin
        h_act = 12'd1920; h_ss = 12'd2008; h_se = 12'd2052; h_bl = 12'd2200;
        v_act = 12'd1080; v_ss = 12'd1084; v_se = 12'd1089; v_bl = 12'd1125;
        hpol = 1'b1; vpol = 1'b1;
      end
      default: begin
        h_act = 12'd640;  h_ss = 12'd656;  h_se = 12'd752;  h_bl = 12'd800;
        v_act = 12'd480;  v_ss = 12'd490;  v_se = 12'd492;  v_bl = 12'd525;
        hpol = 1'b0; vpol = 1'b0;
      end
    endcase
  end

  // Byte expected at register idx_q; 0x0c is the final (video-on) value,
  // which is also what the readback pass must find there.
  always_comb begin
    ctrl_off = {3'b000, hpol, vpol, 3'b000};
    ctrl_on  = {3'b000, hpol, vpol, out_sel_q[1], out_sel_q[0], 1'b1};
    if (idx_q == CTRL_IDX)
      exp_byte = ctrl_on;
    else if (idx_q < 4'd6)
      exp_byte = pack_byte(idx_q[2:0], h_act, h_ss, h_se, h_bl);
    else
      exp_byte = pack_byte(3'(idx_q - 4'd6), v_act, v_ss, v_se, v_bl);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    out_sel_d = out_sel_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
`ifdef VCTRL_LOADER_VERIFY_EN
    vfail_d   = vfail_q;
`endif
    ld_sel    = 1'b0;
    ld_wr     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    grant     = !i_host_select;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_mode[2]) begin
            err_d = 1'b1;
          end else begin
            mode_d    = i_mode[1:0];
            out_sel_d = i_out_sel;
            idx_d     = '0;
            state_d   = S_BLANK;
`ifdef VCTRL_LOADER_VERIFY_EN
            vfail_d   = 1'b0;
`endif
          end
        end
      end
      S_BLANK: begin
        ld_sel  = 1'b1;
        ld_wr   = 1'b1;
        ld_addr = ADDR_W'(CTRL_IDX);
        ld_data = DATA_W'(ctrl_off);
        if (grant) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_sel  = 1'b1;
        ld_wr   = 1'b1;
        ld_addr = ADDR_W'(idx_q);
        ld_data = DATA_W'(exp_byte);
        if (grant) begin
          if (idx_q == LAST_TIMING) begin
            idx_d   = CTRL_IDX;
            state_d = S_ENABLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ENABLE: begin
        ld_sel  = 1'b1;
        ld_wr   = 1'b1;
        ld_addr = ADDR_W'(CTRL_IDX);
        ld_data = DATA_W'(ctrl_on);
        if (grant) begin
          idx_d = '0;
`ifdef VCTRL_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_FINISH;
`endif
        end
      end
`ifdef VCTRL_LOADER_VERIFY_EN
      S_VERIFY: begin
        ld_sel  = 1'b1;
        ld_addr = ADDR_W'(idx_q);
        if (grant) begin
          if (i_data_rd != DATA_W'(exp_byte)) vfail_d = 1'b1;
          if (idx_q == CTRL_IDX) state_d = S_FINISH;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      out_sel_q <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      out_sel_q <= out_sel_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

`ifdef VCTRL_LOADER_VERIFY_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) vfail_q <= 1'b0;
    else            vfail_q <= vfail_d;
  end
  assign o_verify_fail = vfail_q;
`else
  assign o_verify_fail = 1'b0;
`endif

  assign o_host_data = i_data_rd;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign o_done      = (state_q == S_FINISH);
  assign o_err       = err_q;
  assign o_select    = i_host_select ? 1'b1          : ld_sel;
  assign o_wr_req    = i_host_select ? i_host_wr_req : ld_wr;
  assign o_addr      = i_host_select ? i_host_addr   : ld_addr;
  assign o_data_wr   = i_host_select ? i_host_data   : ld_data;

endmodule

// File: tb/tb_vctrl_mode_loader.sv
// Self-checking bench for vctrl_mode_loader: a small register-file model
// sits on the shared port, expected loader writes are queued when a load is
// started and popped as the writes appear on the bus.
module tb_vctrl_mode_loader;

`ifdef VCTRL_LOADER_VERIFY_EN
  localparam int DONE_LAT = 28;
`else
  localparam int DONE_LAT = 15;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] h_addr;
  logic [7:0] h_data;
  logic       h_sel, h_wr;
  logic [7:0] host_rd;
  logic [2:0] mode;
  logic [1:0] osel;
  logic       start;
  logic       busy, done, err, vfail;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       sel, wr;
  logic [7:0] rdata;
  logic       corrupt5;

  logic [7:0] regs [0:31];
  logic [12:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  int tbl [4][8] = '{
    '{640, 656, 752, 800, 480, 490, 492, 525},
    '{800, 840, 968, 1056, 600, 601, 605, 628},
    '{1280, 1390, 1430, 1650, 720, 725, 730, 750},
    '{1920, 2008, 2052, 2200, 1080, 1084, 1089, 1125}
  };

  vctrl_mode_loader dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_host_addr   (h_addr),
    .i_host_data   (h_data),
    .i_host_select (h_sel),
    .i_host_wr_req (h_wr),
    .o_host_data   (host_rd),
    .i_mode        (mode),
    .i_out_sel     (osel),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_verify_fail (vfail),
    .o_addr        (addr),
    .o_data_wr     (wdata),
    .o_select      (sel),
    .o_wr_req      (wr),
    .i_data_rd     (rdata)
  );

  always_comb begin
    rdata = regs[addr];
    if (corrupt5 && addr == 5'd5 && !wr) rdata = rdata ^ 8'hFF;
  end

  always @(posedge clk) if (sel && wr) regs[addr] <= wdata;

  function automatic logic [7:0] exp_byte(input int m, input int a);
    int g, b;
    logic [11:0] act, ss, se, bl;
    g = a / 6;
    b = a % 6;
    act = 12'(tbl[m][g*4]);
    ss  = 12'(tbl[m][g*4+1]);
    se  = 12'(tbl[m][g*4+2]);
    bl  = 12'(tbl[m][g*4+3]);
    case (b)
      0:       return act[7:0];
      1:       return {ss[3:0], act[11:8]};
      2:       return ss[11:4];
      3:       return se[7:0];
      4:       return {bl[3:0], se[11:8]};
      default: return bl[11:4];
    endcase
  endfunction

  task automatic push_load(input int m, input logic [1:0] os);
    logic p;
    p = (m != 0);
    exp_q.push_back({5'h0c, 3'b000, p, p, 3'b000});
    for (int a = 0; a < 12; a++) exp_q.push_back({5'(a), exp_byte(m, a)});
    exp_q.push_back({5'h0c, 3'b000, p, p, os[1], os[0], 1'b1});
  endtask

  // Starts a load at k=0, optionally holds the host on the bus for
  // host_len cycles from host_from, and pulses a conflicting start at
  // restart_k. Loader writes are popped from the scoreboard as they appear.
  task automatic run_load(input logic [2:0] m, input logic [1:0] os,
                          input int host_from, input int host_len, input int restart_k,
                          output int done_at, output logic vfail_at_done);
    logic hs;
    logic [12:0] ew;
    done_at = -1;
    vfail_at_done = 1'bx;
    push_load(int'(m), os);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      hs     = (k >= host_from) && (k < host_from + host_len);
      start  = (k == 0) || (k == restart_k);
      mode   = (k == 0) ? m : 3'd3;
      osel   = (k == 0) ? os : 2'b10;
      h_sel  = hs;
      h_wr   = hs;
      h_addr = 5'h1f;
      h_data = 8'h5a ^ 8'(k);
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
        else n_pass++;
      end
      if (hs) begin
        n_checks++;
        if ({sel, wr, addr, wdata} !== {1'b1, 1'b1, 5'h1f, h_data})
          $display("FAIL host_mirror k=%0d: got sel=%b wr=%b addr=%h data=%h want 1 1 1f %h",
                   k, sel, wr, addr, wdata, h_data);
        else n_pass++;
      end else if (sel && wr) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_write k=%0d: got addr=%h data=%h want none", k, addr, wdata);
        end else begin
          ew = exp_q.pop_front();
          if ({addr, wdata} !== ew)
            $display("FAIL load_write k=%0d: got addr=%h data=%h want addr=%h data=%h",
                     k, addr, wdata, ew[12:8], ew[7:0]);
          else n_pass++;
        end
      end
      if (done === 1'b1) begin
        done_at = k;
        vfail_at_done = vfail;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy);
        else n_pass++;
        break;
      end
    end
    start = 1'b0; h_sel = 1'b0; h_wr = 1'b0;
    n_checks++;
    if (done_at < 0) $display("FAIL done_timeout: got no done want done");
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL missing_writes: got %0d left want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sel, wr, addr, wdata} !== 15'd0)
      $display("FAIL reset_bus: got sel=%b wr=%b addr=%h data=%h want 0", sel, wr, addr, wdata);
    else n_pass++;
    n_checks++;
    if ({busy, done, err, vfail} !== 4'd0)
      $display("FAIL reset_status: got %b want 0000", {busy, done, err, vfail});
    else n_pass++;
    n_checks++;
    if (host_rd !== 8'h77) $display("FAIL host_readback: got %h want 77", host_rd);
    else n_pass++;
  endtask

  task automatic test_mode0();
    int d; logic vf;
    run_load(3'd0, 2'b01, -1, 0, -1, d, vf);
    n_checks++;
    if (d !== DONE_LAT) $display("FAIL mode0_latency: got %0d want %0d", d, DONE_LAT);
    else n_pass++;
    n_checks++;
    if (vf !== 1'b0) $display("FAIL mode0_vfail: got %b want 0", vf);
    else n_pass++;
  endtask

  task automatic test_mode3();
    int d; logic vf;
    run_load(3'd3, 2'b11, -1, 0, -1, d, vf);
    n_checks++;
    if (regs[12] !== 8'h1f) $display("FAIL mode3_ctrl: got %h want 1f", regs[12]);
    else n_pass++;
  endtask

  task automatic test_invalid_mode();
    int bad;
    @(posedge clk); #1;
    start = 1'b1; mode = 3'd5; osel = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({err, busy, sel} !== 3'b100)
      $display("FAIL invalid_err: got err=%b busy=%b sel=%b want 1 0 0", err, busy, sel);
    else n_pass++;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (err || busy || sel) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL invalid_quiet: got %0d active cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_host_contention();
    int d; logic vf;
    run_load(3'd2, 2'b10, 5, 3, -1, d, vf);
    n_checks++;
    if (d !== DONE_LAT + 3) $display("FAIL host_latency: got %0d want %0d", d, DONE_LAT + 3);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int d; logic vf;
    run_load(3'd1, 2'b01, -1, 0, 3, d, vf);
    n_checks++;
    if (d !== DONE_LAT) $display("FAIL busy_restart_latency: got %0d want %0d", d, DONE_LAT);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    int bad, d;
    logic vf;
    logic [7:0] old4;
    old4 = regs[4];
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start = (k == 0);
      mode  = 3'd0;
      osel  = 2'b01;
      rst_n = (k != 5);
      @(negedge clk);
      if (k == 5) begin
        n_checks++;
        if ({sel, wr, addr, wdata} !== {1'b1, 1'b1, 5'h03, exp_byte(0, 3)})
          $display("FAIL fifth_write: got sel=%b wr=%b addr=%h data=%h want 1 1 03 %h",
                   sel, wr, addr, wdata, exp_byte(0, 3));
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, vfail, sel, wr, addr, wdata} !== 19'd0)
      $display("FAIL abort_outputs: got busy=%b done=%b sel=%b wr=%b addr=%h want 0",
               busy, done, sel, wr, addr);
    else n_pass++;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done || sel || busy) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_no_done: got %0d active cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if ({regs[3], regs[4]} !== {exp_byte(0, 3), old4})
      $display("FAIL abort_regs: got %h %h want %h %h", regs[3], regs[4], exp_byte(0, 3), old4);
    else n_pass++;
    run_load(3'd0, 2'b01, -1, 0, -1, d, vf);
    n_checks++;
    if ({d, vf} !== {DONE_LAT, 1'b0})
      $display("FAIL recovery: got done=%0d vfail=%b want %0d 0", d, vf, DONE_LAT);
    else n_pass++;
  endtask

`ifdef VCTRL_LOADER_VERIFY_EN
  task automatic test_verify();
    int d; logic vf;
    corrupt5 = 1'b1;
    run_load(3'd0, 2'b01, -1, 0, -1, d, vf);
    corrupt5 = 1'b0;
    n_checks++;
    if (vf !== 1'b1) $display("FAIL verify_corrupt: got %b want 1", vf);
    else n_pass++;
    run_load(3'd0, 2'b01, -1, 0, -1, d, vf);
    n_checks++;
    if ({d, vf} !== {DONE_LAT, 1'b0})
      $display("FAIL verify_clean: got done=%0d vfail=%b want %0d 0", d, vf, DONE_LAT);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    regs[0]  = 8'h77;
    corrupt5 = 1'b0;
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; osel = 2'b00;
    h_sel = 1'b0; h_wr = 1'b0; h_addr = 5'd0; h_data = 8'd0;
    test_reset();
    test_mode0();
    test_mode3();
    test_invalid_mode();
    test_host_contention();
    test_start_while_busy();
    test_reset_midload();
`ifdef VCTRL_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
